// File: rtl/usb_rx_response_ctrl.sv
// Host-side USB receive response sequencer: supervises the decoder after a transmit, times out, retries, reports status.
// Optional macro USB_RX_RETRY_EN enables NAK/timeout retries; undefined means the first NAK or timeout ends the transaction.
module usb_rx_response_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       expect_data,
    input  logic       tx_done,
    input  logic       rec_start,
    input  logic       ACK_rec,
    input  logic       NAK_rec,
    input  logic       DATA0_rec,
    input  logic       load_data,
    input  logic       crc_ok,
    output logic       busy,
    output logic       bus_release,
    output logic       retry_req,
    output logic       done,
    output logic [2:0] status,
    output logic [3:0] retry_count
);

    // IDLE: wait start | WAIT_TX: packet in flight | LISTEN: await PID | RECV_DATA: await EOP | RETRY: resend | DONE: report
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TX, S_LISTEN, S_RECV_DATA, S_RETRY, S_DONE
    } state_t;

`ifdef USB_RX_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);

    localparam logic [2:0] ST_NONE     = 3'b000;
    localparam logic [2:0] ST_ACK      = 3'b001;
    localparam logic [2:0] ST_NAK      = 3'b010;
    localparam logic [2:0] ST_DATA_OK  = 3'b011;
    localparam logic [2:0] ST_TIMEOUT  = 3'b100;
    localparam logic [2:0] ST_CRC_ERR  = 3'b101;
    localparam logic [2:0] ST_PROTOCOL = 3'b110;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic        seen_q, seen_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  status_q, status_d;
    logic        busy_q, bus_release_q, retry_req_q, done_q;
    logic        retry_ok;
    logic        timeout;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        seen_d   = seen_q;
        timer_d  = timer_q;
        count_d  = count_q;
        status_d = status_q;
        retry_ok = RETRY_EN && (count_q < RETRY_MAX);
        timeout  = (timer_q == TIMER_LAST) && !seen_q && !rec_start;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = expect_data;
                    count_d  = 4'd0;
                    status_d = ST_NONE;
                    state_d  = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    timer_d = 16'd0;
                    seen_d  = 1'b0;
                    state_d = S_LISTEN;
                end
            end
            S_LISTEN: begin
                if (rec_start || seen_q) begin
                    seen_d = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
                // PIDs are checked before expiry so a PID on the last cycle wins
                if (ACK_rec && !mode_q) begin
                    status_d = ST_ACK;
                    state_d  = S_DONE;
                end else if (DATA0_rec && mode_q) begin
                    state_d = S_RECV_DATA;
                end else if (NAK_rec || (!ACK_rec && !DATA0_rec && timeout)) begin
                    if (retry_ok) begin
                        count_d = count_q + 4'd1;
                        state_d = S_RETRY;
                    end else begin
                        status_d = NAK_rec ? ST_NAK : ST_TIMEOUT;
                        state_d  = S_DONE;
                    end
                end else if (ACK_rec || DATA0_rec) begin
                    status_d = ST_PROTOCOL;
                    state_d  = S_DONE;
                end
            end
            S_RECV_DATA: begin
                if (load_data) begin
                    status_d = crc_ok ? ST_DATA_OK : ST_CRC_ERR;
                    state_d  = S_DONE;
                end
            end
            S_RETRY: state_d = S_WAIT_TX;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            seen_q        <= 1'b0;
            timer_q       <= 16'd0;
            count_q       <= 4'd0;
            status_q      <= ST_NONE;
            busy_q        <= 1'b0;
            bus_release_q <= 1'b0;
            retry_req_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            seen_q        <= seen_d;
            timer_q       <= timer_d;
            count_q       <= count_d;
            status_q      <= status_d;
            busy_q        <= (state_d != S_IDLE);
            bus_release_q <= (state_d == S_LISTEN) || (state_d == S_RECV_DATA);
            retry_req_q   <= RETRY_EN && (state_d == S_RETRY);
            done_q        <= (state_d == S_DONE);
        end
    end

    assign busy        = busy_q;
    assign bus_release = bus_release_q;
    assign retry_req   = retry_req_q;
    assign done        = done_q;
    assign status      = status_q;
    assign retry_count = count_q;

endmodule

// File: tb/tb_usb_rx_response_ctrl.sv
// Directed self-checking bench for usb_rx_response_ctrl (TIMEOUT_CYCLES=20, MAX_RETRY=3).
module tb_usb_rx_response_ctrl;

`ifdef USB_RX_RETRY_EN
    localparam int RETRIES = 3;
`else
    localparam int RETRIES = 0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, expect_data = 1'b0, tx_done = 1'b0, rec_start = 1'b0;
    logic       ACK_rec = 1'b0, NAK_rec = 1'b0, DATA0_rec = 1'b0, load_data = 1'b0, crc_ok = 1'b0;
    logic       busy, bus_release, retry_req, done;
    logic [2:0] status;
    logic [3:0] retry_count;

    int n_assert = 0;
    int n_fail   = 0;

    usb_rx_response_ctrl #(.TIMEOUT_CYCLES(20), .MAX_RETRY(3)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .expect_data(expect_data),
        .tx_done(tx_done), .rec_start(rec_start), .ACK_rec(ACK_rec), .NAK_rec(NAK_rec),
        .DATA0_rec(DATA0_rec), .load_data(load_data), .crc_ok(crc_ok),
        .busy(busy), .bus_release(bus_release), .retry_req(retry_req), .done(done),
        .status(status), .retry_count(retry_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Packed order: busy, bus_release, retry_req, done, status[2:0], retry_count[3:0]
    task automatic expect_outs(input string tag, input logic b, input logic br, input logic rr,
                               input logic d, input logic [2:0] st, input logic [3:0] rc);
        logic [10:0] o;
        logic [10:0] e;
        o = {busy, bus_release, retry_req, done, status, retry_count};
        e = {b, br, rr, d, st, rc};
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (busy,rel,retry,done,status,count)", tag, o, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (2) tick();
        expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0);
        reset_n = 1'b1;
        tick();
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        expect_outs("txdone_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0);

        // Handshake ACK, with a start while busy that must not switch the mode
        start = 1'b1; expect_data = 1'b0; tick(); start = 1'b0;
        expect_outs("t1_busy", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0);
        start = 1'b1; expect_data = 1'b1; tick(); start = 1'b0; expect_data = 1'b0;
        expect_outs("t1_start_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        expect_outs("t1_listen", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0);
        repeat (4) tick();
        ACK_rec = 1'b1; tick(); ACK_rec = 1'b0;
        expect_outs("t1_done", 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 4'd0);
        tick();
        expect_outs("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 4'd0);

        // NAK on every attempt
        start = 1'b1; tick(); start = 1'b0;
        expect_outs("t2_start", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0);
        for (int a = 0; a <= RETRIES; a++) begin
            tx_done = 1'b1; tick(); tx_done = 1'b0;
            expect_outs("t2_listen", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'(a));
            tick();
            NAK_rec = 1'b1; tick(); NAK_rec = 1'b0;
            if (a < RETRIES) begin
                expect_outs("t2_retry", 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 4'(a + 1));
                tick();
                expect_outs("t2_rewait", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 4'(a + 1));
            end else begin
                expect_outs("t2_done", 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 4'(RETRIES));
            end
        end
        tick();
        expect_outs("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 4'(RETRIES));

        // Timeout with no decoder activity: event lands 20 cycles after bus_release rises
        start = 1'b1; tick(); start = 1'b0;
        for (int a = 0; a <= RETRIES; a++) begin
            tx_done = 1'b1; tick(); tx_done = 1'b0;
            expect_outs("t3_listen", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'(a));
            repeat (19) tick();
            expect_outs("t3_pre_expiry", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'(a));
            tick();
            if (a < RETRIES) begin
                expect_outs("t3_retry", 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 4'(a + 1));
                tick();
            end else begin
                expect_outs("t3_done", 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 4'(RETRIES));
            end
        end
        tick();
        expect_outs("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 4'(RETRIES));

        // Data path, CRC good
        start = 1'b1; expect_data = 1'b1; tick(); start = 1'b0; expect_data = 1'b0;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        DATA0_rec = 1'b1; tick(); DATA0_rec = 1'b0;
        expect_outs("t4_recv", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0);
        repeat (3) tick();
        load_data = 1'b1; crc_ok = 1'b1; tick(); load_data = 1'b0; crc_ok = 1'b0;
        expect_outs("t4_data_ok", 1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 4'd0);
        tick();

        // Data path, CRC bad; a stray NAK during RECV_DATA is ignored
        start = 1'b1; expect_data = 1'b1; tick(); start = 1'b0; expect_data = 1'b0;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        DATA0_rec = 1'b1; tick(); DATA0_rec = 1'b0;
        NAK_rec = 1'b1; tick(); NAK_rec = 1'b0;
        expect_outs("t4b_recv_hold", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0);
        load_data = 1'b1; crc_ok = 1'b0; tick(); load_data = 1'b0;
        expect_outs("t4b_crc_err", 1'b1, 1'b0, 1'b0, 1'b1, 3'b101, 4'd0);
        tick();

        // ACK in data mode: protocol error, no retry
        start = 1'b1; expect_data = 1'b1; tick(); start = 1'b0; expect_data = 1'b0;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        ACK_rec = 1'b1; tick(); ACK_rec = 1'b0;
        expect_outs("t5_ack_data_mode", 1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 4'd0);
        tick();

        // DATA0 in handshake mode: protocol error
        start = 1'b1; tick(); start = 1'b0;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        DATA0_rec = 1'b1; tick(); DATA0_rec = 1'b0;
        expect_outs("t5b_data0_hs_mode", 1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 4'd0);
        tick();

        // ACK in the same cycle as timer expiry wins
        start = 1'b1; tick(); start = 1'b0;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        repeat (19) tick();
        ACK_rec = 1'b1; tick(); ACK_rec = 1'b0;
        expect_outs("t6_ack_at_expiry", 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 4'd0);
        tick();

        // rec_start freezes the timer, so no timeout follows
        start = 1'b1; tick(); start = 1'b0;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        tick();
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        repeat (25) tick();
        expect_outs("t7_frozen", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0);
        ACK_rec = 1'b1; tick(); ACK_rec = 1'b0;
        expect_outs("t7_done", 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 4'd0);
        tick();

        // Reset mid-LISTEN
        start = 1'b1; tick(); start = 1'b0;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        expect_outs("t8_reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            expect_outs("t8_quiet", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'd0);
        end
        start = 1'b1; tick(); start = 1'b0;
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        expect_outs("t8_listen", 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 4'd0);
        ACK_rec = 1'b1; tick(); ACK_rec = 1'b0;
        expect_outs("t8_done", 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 4'd0);
        tick();
        expect_outs("t8_idle", 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
